// File: rtl/tb_uart_pkg.sv
// Shared types and constants for the testbench UART receive monitor.
package tb_uart_pkg;

  localparam int UART_BAUD_DIV_MIN = 4;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/tb_uart_mon_fifo.sv
// First-word-fall-through receive FIFO for the UART monitor.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module tb_uart_mon_fifo
  import tb_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk_sys,
  input  logic                      rst_n_por,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      wr_en;
  logic                      rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  // Drive zero while empty so the head reads 0x00 out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tb_uart_rx_monitor.sv
// 8N1 UART receive monitor: deserialises rx into a valid/ready byte stream with sticky error flags.
// Define TB_UART_MON_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO instead of one holding register.
module tb_uart_rx_monitor
  import tb_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk_sys,
  input  logic                      rst_n_por,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      framing_err,
  output logic                      overflow,
  input  logic                      clr_err
);

  if (BAUD_DIV < UART_BAUD_DIV_MIN || BAUD_DIV > 65535 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("tb_uart_rx_monitor: illegal BAUD_DIV or FIFO_DEPTH");
  end

  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF   = 16'(BAUD_DIV / 2 - 1);

  logic                      rx_meta;
  logic                      rx_s;
  logic [15:0]               baud_cnt;
  logic                      strobe;
  uart_rx_state_t            state;
  uart_rx_state_t            state_nxt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      load_half;
  logic                      clr_idx;
  logic                      shift_en;
  logic                      push;
  logic                      set_ferr;
  logic                      set_ovf;
  logic                      pop;
  logic                      full;

  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // A start edge loads half a bit so every later strobe lands mid-bit.
  assign strobe = (baud_cnt == '0);

  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por)     baud_cnt <= '0;
    else if (load_half) baud_cnt <= HALF;
    else if (strobe)    baud_cnt <= RELOAD;
    else                baud_cnt <= baud_cnt - 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    clr_idx   = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          load_half = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (strobe) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            clr_idx   = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          push      = rx_s;
          set_ferr  = !rx_s;
          state_nxt = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (clr_idx)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (shift_en)      shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
    end
  end

  assign pop     = rx_valid && rx_ready;
  assign set_ovf = push && full && !pop;

  // A new error event outranks a coincident clear.
  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) begin
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (set_ferr)     framing_err <= 1'b1;
      else if (clr_err) framing_err <= 1'b0;
      if (set_ovf)      overflow    <= 1'b1;
      else if (clr_err) overflow    <= 1'b0;
    end
  end

`ifdef TB_UART_MON_FIFO_EN
  logic fifo_empty;

  tb_uart_mon_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .rst_n_por(rst_n_por),
    .push     (push),
    .pop      (pop),
    .wr_data  (shreg),
    .rd_data  (rx_data),
    .full     (full),
    .empty    (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
`else
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;

  assign full     = hold_valid;
  assign rx_valid = hold_valid;
  assign rx_data  = hold_data;

  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= shreg;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_tb_uart_rx_monitor.sv
// Scoreboard bench for tb_uart_rx_monitor: stimulus queues expected bytes, a monitor checks transfers.
module tb_tb_uart_rx_monitor;
  import tb_uart_pkg::*;

  localparam int BAUD  = 16;
  localparam int DEPTH = 16;
`ifdef TB_UART_MON_FIFO_EN
  localparam int HOLD  = DEPTH;
`else
  localparam int HOLD  = 1;
`endif
  localparam int STOP_LAT = 2 + BAUD / 2 + 9 * BAUD;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t exp_q[$];

  logic       clk_sys   = 1'b0;
  logic       rst_n_por = 1'b0;
  logic       rx        = 1'b1;
  logic       rx_ready  = 1'b0;
  logic       clr_err   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overflow;

  int cyc          = 0;
  int n_compared   = 0;
  int n_mismatched = 0;

  tb_uart_rx_monitor #(
    .BAUD_DIV  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n_por  (rst_n_por),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .framing_err(framing_err),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One 8N1 frame; the posedge following negedge i is frame edge i.
  task automatic applyStimulus(input logic [7:0] data, input bit expect_push,
                               input bit pop_at_stop, input bit check_latency);
    logic [9:0] frame;
    int         t0;
    exp_t       e;
    frame = {1'b1, data, 1'b0};
    @(negedge clk_sys);
    t0 = cyc;
    if (expect_push) begin
      e.data = data;
      e.due  = check_latency ? t0 + STOP_LAT + 1 : -1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10 * BAUD; i++) begin
      if (i > 0) @(negedge clk_sys);
      rx = frame[i / BAUD];
      if (pop_at_stop && i == STOP_LAT)     rx_ready = 1'b1;
      if (pop_at_stop && i == STOP_LAT + 1) rx_ready = 1'b0;
    end
  endtask

  task automatic applyBreak(input bit check_timing);
    @(negedge clk_sys);
    rx = 1'b0;
    for (int i = 1; i <= 12 * BAUD; i++) begin
      @(negedge clk_sys);
      if (check_timing && i == STOP_LAT)     checkOutput("ferr_before_stop", framing_err, 0);
      if (check_timing && i == STOP_LAT + 1) checkOutput("ferr_after_stop", framing_err, 1);
    end
    rx = 1'b1;
    waitCycles(4 * BAUD);
  endtask

  task automatic pulseClear();
    @(negedge clk_sys);
    clr_err = 1'b1;
    @(negedge clk_sys);
    clr_err = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      #1;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no transfer (cycle %0d)", rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rx_data", rx_data, e.data);
          if (e.due >= 0) checkOutput("valid_latency", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b8;

    repeat (3) @(negedge clk_sys);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_framing_err", framing_err, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst_n_por = 1'b1;
    waitCycles(4);

    $display("[TB] single byte");
    rx_ready = 1'b1;
    applyStimulus(8'h55, 1, 0, 1);
    waitCycles(20);
    checkOutput("t1_framing_err", framing_err, 0);
    checkOutput("t1_overflow", overflow, 0);
    checkOutput("t1_drained", exp_q.size(), 0);

    $display("[TB] glitch rejection");
    @(negedge clk_sys);
    rx = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_sys);
      if (i == 4)  rx = 1'b1;
      if (i == 6)  checkOutput("t2_state_start", dut.state, START);
      if (i == 12) checkOutput("t2_state_idle", dut.state, IDLE);
    end
    waitCycles(10 * BAUD);
    checkOutput("t2_rx_valid", rx_valid, 0);
    checkOutput("t2_framing_err", framing_err, 0);
    checkOutput("t2_overflow", overflow, 0);

    $display("[TB] break");
    applyBreak(1);
    checkOutput("t3_state_idle", dut.state, IDLE);
    applyStimulus(8'hA3, 1, 0, 0);
    waitCycles(20);
    checkOutput("t3_ferr_sticky", framing_err, 1);
    pulseClear();
    checkOutput("t3_ferr_cleared", framing_err, 0);
    waitCycles(2 * BAUD);
    checkOutput("t3_ferr_stays_clear", framing_err, 0);
    checkOutput("t3_drained", exp_q.size(), 0);

    $display("[TB] burst and overflow");
    rx_ready = 1'b0;
    for (int b = 0; b < 17; b++) begin
      b8 = b[7:0];
      applyStimulus(b8, b < HOLD, 0, 0);
      if (b == HOLD - 1) checkOutput("t4_no_overflow_yet", overflow, 0);
    end
    waitCycles(2);
    checkOutput("t4_overflow", overflow, 1);
    checkOutput("t4_head_valid", rx_valid, 1);
    checkOutput("t4_head_byte", rx_data, 8'h00);
    pulseClear();
    checkOutput("t4_overflow_cleared", overflow, 0);
    rx_ready = 1'b1;
    waitCycles(DEPTH + 8);
    checkOutput("t4_drained", exp_q.size(), 0);
    checkOutput("t4_empty", rx_valid, 0);

    $display("[TB] push/pop collision");
    rx_ready = 1'b0;
    for (int b = 0; b < HOLD; b++) begin
      b8 = 8'h20 + b[7:0];
      applyStimulus(b8, 1, 0, 0);
    end
    applyStimulus(8'h30, 1, 1, 0);
    waitCycles(2);
    checkOutput("t5_no_overflow", overflow, 0);
    checkOutput("t5_new_byte_held", rx_valid, 1);
    rx_ready = 1'b1;
    waitCycles(DEPTH + 8);
    checkOutput("t5_drained", exp_q.size(), 0);

    $display("[TB] mid-frame reset");
    rx_ready = 1'b0;
    applyStimulus(8'h5A, 0, 0, 0);
    applyBreak(0);
    checkOutput("t6_pre_valid", rx_valid, 1);
    checkOutput("t6_pre_data", rx_data, 8'h5A);
    checkOutput("t6_pre_ferr", framing_err, 1);
    fork
      applyStimulus(8'hFF, 0, 0, 0);
      begin
        repeat (70) @(negedge clk_sys);
        checkOutput("t6_in_data_state", dut.state, DATA);
        rst_n_por = 1'b0;
        #1;
        checkOutput("t6_rst_rx_data", rx_data, 8'h00);
        checkOutput("t6_rst_rx_valid", rx_valid, 0);
        checkOutput("t6_rst_framing_err", framing_err, 0);
        checkOutput("t6_rst_overflow", overflow, 0);
        checkOutput("t6_rst_state", dut.state, IDLE);
      end
    join
    waitCycles(4);
    rst_n_por = 1'b1;
    waitCycles(4);
    rx_ready = 1'b1;
    applyStimulus(8'h3C, 1, 0, 1);
    waitCycles(20);
    checkOutput("t6_framing_err", framing_err, 0);
    checkOutput("t6_overflow", overflow, 0);
    checkOutput("final_scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/tb_uart_rx_monitor.md
# tb_uart_rx_monitor

Synthesisable 8N1 UART receive monitor for the system testbench. It sits directly downstream of the SoC's `uart_tx` pin and deserialises the transmitted characters. It then presents them as bytes on a valid/ready stream, so the bench (or a later self-checking stage) can consume console output without a behavioural model. Line errors are captured in sticky flags.

## Interface
- `BAUD_DIV`, 16: `clk_sys` cycles per bit; legal range 4..65535.
- `FIFO_DEPTH`, 16: receive buffer entries; power of two, at least 2. Used only when the FIFO is compiled in.
- `clk_sys` input 1: the single clock.
- `rst_n_por` input 1: reset, asynchronous and active-low.
- `rx` input 1: serial line, connected to the SoC `uart_tx`; idle high.
- `rx_data` output 8: head byte; valid only while `rx_valid` is high.
- `rx_valid` output 1: a byte is available.
- `rx_ready` input 1: consumer accepts the byte; a transfer occurs when `rx_valid && rx_ready`.
- `framing_err` output 1: sticky; stop bit was sampled low.
- `overflow` output 1: sticky; a completed byte was dropped because the buffer was full.
- `clr_err` input 1: synchronous clear of both sticky flags.

## Operation
- **Input sync.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised value `rx_s`.
- **Bit timer.** A down-counter, 16 bits wide, generates a sample strobe when it reaches 0. On the strobe it reloads to `BAUD_DIV-1`.
- **FSM states.** IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- **IDLE.**
  - When `rx_s` is 0 (start edge): load the counter with `BAUD_DIV/2-1` (integer division) and go to START.
- **START.**
  - On the strobe, if `rx_s` is 1: false start; return to IDLE with no flag set.
  - Otherwise clear the bit index and go to DATA.
- **DATA.**
  - On each strobe, shift `rx_s` into the shift register, LSB first, and increment the 3-bit bit index.
  - After bit 7 is sampled, go to STOP.
- **STOP.** On the strobe:
  - If `rx_s` is 1: push the shift register into the buffer and go to IDLE.
  - If `rx_s` is 0: set `framing_err`, discard the byte, and go to WAIT_HIGH.
- **WAIT_HIGH.**
  - Stay until `rx_s` is 1, then go to IDLE. This ensures a break condition produces exactly one framing error.
- **Push when full.**
  - If the buffer is full and no pop occurs in the same cycle, drop the byte and set `overflow`.
  - If a pop occurs in the same cycle, accept the push.
- **Flag priority.** When `clr_err` coincides with a new error event, the set wins.
- **Reset mid-frame.** The FSM returns to IDLE, the buffer empties and the flags clear. A partially received frame is lost. If `rx` is still low on release, that low level is treated as a new start edge.

## Timing
- **Reset values.**
  - `rx_data` = 0x00, `rx_valid` = 0, `framing_err` = 0, `overflow` = 0.
  - Synchroniser flops = 1; counter = 0; state = IDLE.
- **Stop-bit sample.** Occurs `2 + BAUD_DIV/2 + 9*BAUD_DIV` cycles after the first `clk_sys` edge at which `rx` is low.
- **Byte visible.** `rx_valid` rises on the cycle after that stop-bit strobe; the buffer is first-word-fall-through.
- **Pop.** `rx_data` and `rx_valid` update on the cycle after `rx_valid && rx_ready`.
- **Back-to-back pops.** Sustained one byte per cycle.
- **Back-to-back frames.** Supported: a start edge is accepted in the cycle after the STOP→IDLE transition. Up to half a bit of tolerance is available for transmitter drift.
- **Flags.** `framing_err` and `overflow` assert one cycle after the offending strobe. They deassert one cycle after `clr_err` is sampled high.

## Configuration
- Macro: `TB_UART_MON_FIFO_EN`.
- **Defined:** a `FIFO_DEPTH`-entry FWFT FIFO buffers received bytes. "Full" means `FIFO_DEPTH` entries are held.
- **Undefined:** a single holding register replaces the FIFO, and `FIFO_DEPTH` is ignored. "Full" means `rx_valid` is high, so a second byte arriving before the first is popped sets `overflow`. The same-cycle push-and-pop rule still applies.

## Structure
- **Package `tb_uart_pkg`:**
  - FSM state enum `uart_rx_state_t`.
  - Constant `UART_BAUD_DIV_MIN = 4`.
  - Constant `UART_DATA_BITS = 8`.
- **Sub-module `tb_uart_mon_fifo`:**
  - Synchronous FWFT FIFO with push/pop/full/empty signals.
  - Clocked by `clk_sys` with asynchronous reset `rst_n_por`.
  - Instantiated only under `TB_UART_MON_FIFO_EN`.
- **Parameter check:** an elaboration-time assertion rejects `BAUD_DIV` < 4 and a non-power-of-two `FIFO_DEPTH`.

## Test plan
1. **Single byte.** `BAUD_DIV`=16; drive 0x55 with a correct frame and hold `rx_ready`=1. Expect `rx_valid` for exactly one cycle with `rx_data`=0x55, at cycle 2+8+144+1 after the start edge; both flags stay 0.
2. **Glitch rejection.** Pulse `rx` low for 4 cycles with `BAUD_DIV`=16. Expect no byte and no flags; the FSM is back in IDLE by cycle 12.
3. **Break.** Drive `rx` low for 12 bit times, then release. Expect `framing_err`=1 exactly once and no byte pushed. A following 0xA3 frame is received correctly; `clr_err` clears the flag.
4. **Burst and overflow.** Hold `rx_ready`=0 and send bytes 0x00..0x10 back-to-back (17 bytes).
   - FIFO build: 16 bytes are held and `overflow`=1; draining yields 0x00..0x0F in order.
   - Non-FIFO build: `overflow`=1 after the second byte, and the held byte is 0x00.
5. **Push/pop collision.** With the buffer full, assert `rx_ready` in the cycle of a stop-bit strobe. Expect the new byte accepted and `overflow` to stay 0.
6. **Mid-frame reset.** Assert `rst_n_por` during DATA bit 3 of a 0xFF frame. Expect every output to show its reset value immediately. The next full frame, 0x3C, is received correctly.
